// File: rtl/cla_pkg.sv
// cla_pkg: shared types and sizing helpers for the pipelined carry-lookahead
// adder/subtractor (cla_adder_pipe) and its lookahead group (cla_group).
package cla_pkg;

    typedef enum logic {
        CLA_ADD = 1'b0,
        CLA_SUB = 1'b1
    } cla_op_e;

    // Default geometry: 32 bits, 4-bit groups, 2 groups per stage -> 4 stages
    localparam int CLA_WIDTH            = 32;
    localparam int CLA_GROUP            = 4;
    localparam int CLA_GROUPS_PER_STAGE = 2;

    // Number of pipeline stages; width must be a multiple of group*gps
    function automatic int cla_num_stages(input int width, input int group, input int gps);
        return width / (group * gps);
    endfunction

endpackage

// File: rtl/cla_group.sv
// cla_group: combinational GROUP-bit carry-lookahead block.
// Every internal carry is formed from the prefix generate/propagate of the
// bits below it plus cin, so no carry waits on a neighbouring sum bit.
module cla_group #(
    parameter int GROUP = 4
) (
    input  logic [GROUP-1:0] a,
    input  logic [GROUP-1:0] b,
    input  logic             cin,
    output logic [GROUP-1:0] sum,
    output logic             gen,
    output logic             prop,
    output logic             cout,
    output logic             cmsb
);

    logic [GROUP-1:0] g;
    logic [GROUP-1:0] p;
    logic [GROUP:0]   c;

    assign g = a & b;
    assign p = a ^ b;

    // Prefix generate/propagate per bit position, giving each carry directly
    always_comb begin : p_lookahead
        logic gacc;
        logic pacc;
        gacc = 1'b0;
        pacc = 1'b1;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < GROUP; i++) begin
            gacc     = g[i] | (p[i] & gacc);
            pacc     = pacc & p[i];
            c[i + 1] = gacc | (pacc & cin);
        end
        gen  = gacc;
        prop = pacc;
    end

    assign sum  = p ^ c[GROUP-1:0];
    assign cout = c[GROUP];
    assign cmsb = c[GROUP-1];

endmodule

// File: rtl/cla_adder_pipe.sv
// cla_adder_pipe: valid/ready pipelined carry-lookahead adder/subtractor.
// The word is cut into NUM_STAGES slices of GROUP*GROUPS_PER_STAGE bits;
// slice k is summed in stage k from the carry registered by stage k-1.
// Operand slices wait in skew registers, finished sums in de-skew registers,
// so the whole result leaves the last stage together.
// Optional build macro CLA_FLAGS_EN adds registered overflow/zero flags;
// without it out_overflow/out_zero are tied to 0.
// Requires NUM_STAGES >= 2.
module cla_adder_pipe
    import cla_pkg::*;
#(
    parameter int WIDTH            = CLA_WIDTH,
    parameter int GROUP            = CLA_GROUP,
    parameter int GROUPS_PER_STAGE = CLA_GROUPS_PER_STAGE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_op,
    input  logic             in_carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_carry,
    output logic             out_overflow,
    output logic             out_zero
);

    localparam int SW = GROUP * GROUPS_PER_STAGE;
    localparam int NS = cla_num_stages(WIDTH, GROUP, GROUPS_PER_STAGE);

    logic             advance;
    logic [NS-1:0]    vld_pipe;
    logic [NS-1:0]    cy_q;
    logic [NS-1:0]    cy_nxt;
    logic [WIDTH-1:0] b_eff;
    logic             cin0;
    logic [WIDTH-1:0] fin_nxt;   // full word about to enter the output register
    logic             msb_cin;   // carry into bit WIDTH-1

    // The whole pipe moves as one; a stalled output freezes every stage
    assign advance   = !out_valid | out_ready;
    assign in_ready  = reset & advance;
    assign out_valid = vld_pipe[NS-1];
    assign out_carry = cy_q[NS-1];

    // Subtract as A + ~B + 1; the caller's carry-in only matters for ADD
    assign b_eff = (cla_op_e'(in_op) == CLA_SUB) ? ~in_b : in_b;
    assign cin0  = (cla_op_e'(in_op) == CLA_SUB) ? 1'b1 : in_carry;

    // Valid shift register; bubbles travel exactly like operations
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)       vld_pipe <= '0;
        else if (advance) vld_pipe <= {vld_pipe[NS-2:0], in_valid};
    end

    // Slice carry-outs, each consumed by the next stage one cycle later
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)       cy_q <= '0;
        else if (advance) cy_q <= cy_nxt;
    end

    for (genvar j = 0; j < NS; j++) begin : g_slice
        logic [SW-1:0]                 a_cur;
        logic [SW-1:0]                 b_cur;
        logic [SW-1:0]                 s_cur;
        logic                          c_in;
        logic [NS-j-1:0][SW-1:0]       s_dk;
        logic [GROUPS_PER_STAGE:0]     gc;
        logic [GROUPS_PER_STAGE-1:0]   gg;
        logic [GROUPS_PER_STAGE-1:0]   gp;
        logic [GROUPS_PER_STAGE-1:0]   gco;
        logic [GROUPS_PER_STAGE-1:0]   gcm;
        logic                          unused_grp;

        if (j == 0) begin : g_head
            assign a_cur = in_a[SW-1:0];
            assign b_cur = b_eff[SW-1:0];
            assign c_in  = cin0;
        end else begin : g_skew
            logic [j-1:0][SW-1:0] a_sk;
            logic [j-1:0][SW-1:0] b_sk;

            // Operand slice waits j cycles for its incoming carry
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    a_sk <= '0;
                    b_sk <= '0;
                end else if (advance) begin
                    a_sk[0] <= in_a[j*SW +: SW];
                    b_sk[0] <= b_eff[j*SW +: SW];
                    for (int i = 1; i < j; i++) begin
                        a_sk[i] <= a_sk[i-1];
                        b_sk[i] <= b_sk[i-1];
                    end
                end
            end

            assign a_cur = a_sk[j-1];
            assign b_cur = b_sk[j-1];
            assign c_in  = cy_q[j-1];
        end

        // Group carries chained through group generate/propagate
        assign gc[0] = c_in;
        for (genvar q = 0; q < GROUPS_PER_STAGE; q++) begin : g_grp
            cla_group #(.GROUP(GROUP)) u_grp (
                .a    (a_cur[q*GROUP +: GROUP]),
                .b    (b_cur[q*GROUP +: GROUP]),
                .cin  (gc[q]),
                .sum  (s_cur[q*GROUP +: GROUP]),
                .gen  (gg[q]),
                .prop (gp[q]),
                .cout (gco[q]),
                .cmsb (gcm[q])
            );
            assign gc[q+1] = gg[q] | (gp[q] & gc[q]);
        end
        assign unused_grp = ^{gco, gcm};
        assign cy_nxt[j]  = gc[GROUPS_PER_STAGE];

        // Finished slice rides along until the upper slices catch up
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                s_dk <= '0;
            end else if (advance) begin
                s_dk[0] <= s_cur;
                for (int i = 1; i < NS - j; i++) s_dk[i] <= s_dk[i-1];
            end
        end

        assign out_sum[j*SW +: SW] = s_dk[NS-j-1];

        if (j == NS - 1) begin : g_fin
            assign fin_nxt[j*SW +: SW] = s_cur;
            assign msb_cin             = gcm[GROUPS_PER_STAGE-1];
        end else begin : g_mid
            assign fin_nxt[j*SW +: SW] = s_dk[NS-j-2];
        end
    end

`ifdef CLA_FLAGS_EN
    logic ovf_q;
    logic zero_q;

    // Flags judged on the word as it is loaded into the output register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (advance) begin
            ovf_q  <= msb_cin ^ cy_nxt[NS-1];
            zero_q <= (fin_nxt == '0);
        end
    end

    assign out_overflow = ovf_q;
    assign out_zero     = zero_q;
`else
    logic unused_flags;

    assign out_overflow = 1'b0;
    assign out_zero     = 1'b0;
    assign unused_flags = ^{fin_nxt, msb_cin};
`endif

endmodule

// File: tb/tb_cla_adder_pipe.sv
// Directed bench for cla_adder_pipe: a default 32-bit instance and a
// 16-bit / one-group-per-stage instance sharing clock and reset.
module tb_cla_adder_pipe;

`ifdef CLA_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, in_op, in_carry;
    logic [31:0] in_a, in_b, out_sum;
    logic        out_valid, out_ready, out_carry, out_overflow, out_zero;

    logic        h_in_valid, h_in_ready, h_in_op, h_in_carry;
    logic [15:0] h_in_a, h_in_b, h_out_sum;
    logic        h_out_valid, h_out_ready, h_out_carry, h_out_overflow, h_out_zero;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cla_adder_pipe u_dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_carry(in_carry),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_carry(out_carry),
        .out_overflow(out_overflow), .out_zero(out_zero)
    );

    cla_adder_pipe #(.WIDTH(16), .GROUP(4), .GROUPS_PER_STAGE(1)) u_dut16 (
        .clk(clk), .reset(reset),
        .in_valid(h_in_valid), .in_ready(h_in_ready),
        .in_a(h_in_a), .in_b(h_in_b), .in_op(h_in_op), .in_carry(h_in_carry),
        .out_valid(h_out_valid), .out_ready(h_out_ready),
        .out_sum(h_out_sum), .out_carry(h_out_carry),
        .out_overflow(h_out_overflow), .out_zero(h_out_zero)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Single op on the 32-bit instance; checks latency and all result fields
    task automatic run32(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic op, input logic cin, input logic [31:0] es,
                         input logic ec, input logic eo, input logic ez);
        int n;
        in_valid = 1'b1; in_a = a; in_b = b; in_op = op; in_carry = cin;
        #1;
        chk({tag, ".rdy"}, in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, ".lat"}, n, 3);
        chk({tag, ".sum"}, out_sum, es);
        chk({tag, ".cy"}, out_carry, ec);
        chk({tag, ".ovf"}, out_overflow, FLAGS ? eo : 1'b0);
        chk({tag, ".zero"}, out_zero, FLAGS ? ez : 1'b0);
        @(posedge clk); #1;
    endtask

    task automatic run16(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic op, input logic cin, input logic [15:0] es,
                         input logic ec, input logic eo, input logic ez);
        int n;
        h_in_valid = 1'b1; h_in_a = a; h_in_b = b; h_in_op = op; h_in_carry = cin;
        @(posedge clk); #1;
        h_in_valid = 1'b0;
        n = 0;
        while (!h_out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, ".lat"}, n, 3);
        chk({tag, ".sum"}, h_out_sum, es);
        chk({tag, ".cy"}, h_out_carry, ec);
        chk({tag, ".ovf"}, h_out_overflow, FLAGS ? eo : 1'b0);
        chk({tag, ".zero"}, h_out_zero, FLAGS ? ez : 1'b0);
        @(posedge clk); #1;
    endtask

    // Back-to-back vectors with hand-computed sums and carries
    logic [31:0] va [8] = '{32'h0000_0001, 32'h0000_FFFF, 32'h0000_0010, 32'hF000_0000,
                            32'h0000_0000, 32'h1234_5678, 32'hFFFF_FFFF, 32'h00FF_00FF};
    logic [31:0] vb [8] = '{32'h0000_0002, 32'h0000_0001, 32'h0000_0001, 32'h1000_0000,
                            32'h0000_0001, 32'h8765_4321, 32'hFFFF_FFFF, 32'h0F0F_0F0F};
    logic        vo [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic        vc [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [31:0] vs [8] = '{32'h0000_0003, 32'h0001_0000, 32'h0000_000F, 32'h0000_0000,
                            32'hFFFF_FFFF, 32'h9999_9999, 32'h0000_0000, 32'h100E_100F};
    logic        vcy[8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx_in, idx_out, cyc, stale;
        logic acc;
        logic [31:0] held;

        reset = 1'b0;
        in_valid = 1'b0; in_a = '0; in_b = '0; in_op = 1'b0; in_carry = 1'b0; out_ready = 1'b1;
        h_in_valid = 1'b0; h_in_a = '0; h_in_b = '0; h_in_op = 1'b0; h_in_carry = 1'b0;
        h_out_ready = 1'b1;
        held = '0;
        #2;
        chk("reset.vld", out_valid, 0);
        chk("reset.sum", out_sum, 0);
        chk("reset.cy", out_carry, 0);
        chk("reset.ovf", out_overflow, 0);
        chk("reset.zero", out_zero, 0);
        chk("reset.rdy", in_ready, 0);
        chk("reset.h_vld", h_out_valid, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        run32("add5p3",  32'h0000_0005, 32'h0000_0003, 1'b0, 1'b0, 32'h0000_0008, 1'b0, 1'b0, 1'b0);
        run32("wrap",    32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        run32("subovf",  32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
        run32("sub3m5",  32'h0000_0003, 32'h0000_0005, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        run32("addcin",  32'h1234_5678, 32'h1111_1111, 1'b0, 1'b1, 32'h2345_678A, 1'b0, 1'b0, 1'b0);
        run32("subcin",  32'h0000_000A, 32'h0000_000A, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        run32("addovf",  32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);

        // Backpressure: 8 ops offered back to back, consumer stalls cycles 5-7
        idx_in = 0; idx_out = 0; cyc = 0;
        while (idx_out < 8 && cyc < 60) begin
            out_ready = !(cyc >= 5 && cyc <= 7);
            in_valid  = (idx_in < 8);
            if (idx_in < 8) begin
                in_a = va[idx_in]; in_b = vb[idx_in]; in_op = vo[idx_in]; in_carry = vc[idx_in];
            end
            #1;
            if (cyc == 5) chk("bp.vld5", out_valid, 1);
            if (out_valid && !out_ready) begin
                chk("bp.rdy", in_ready, 0);
                if (cyc == 5) held = out_sum;
                else          chk("bp.hold", out_sum, held);
            end
            acc = in_valid && in_ready;
            if (out_valid && out_ready) begin
                chk("bp.sum", out_sum, vs[idx_out]);
                chk("bp.cy", out_carry, vcy[idx_out]);
                idx_out++;
            end
            @(posedge clk); #1;
            if (acc) idx_in++;
            cyc++;
        end
        chk("bp.count", idx_out, 8);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;

        // Reset with three ops in flight
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_a = va[i]; in_b = vb[i]; in_op = vo[i]; in_carry = vc[i];
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        reset = 1'b0;
        #1;
        chk("rst.vld", out_valid, 0);
        chk("rst.sum", out_sum, 0);
        chk("rst.cy", out_carry, 0);
        chk("rst.ovf", out_overflow, 0);
        chk("rst.zero", out_zero, 0);
        chk("rst.rdy", in_ready, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        stale = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (out_valid) stale++;
        end
        chk("rst.stale", stale, 0);
        run32("postrst", 32'h0000_0100, 32'h0000_0023, 1'b0, 1'b0, 32'h0000_0123, 1'b0, 1'b0, 1'b0);

        // 16-bit, one group per stage
        run16("h.wrap",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        run16("h.subov", 16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0);
        run16("h.addc",  16'h1234, 16'h4321, 1'b0, 1'b1, 16'h5556, 1'b0, 1'b0, 1'b0);
        run16("h.sub",   16'h0003, 16'h0005, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0, 1'b0);
        run16("h.addov", 16'h7000, 16'h1000, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cla_adder_pipe.md
# cla_adder_pipe

Parametrised, valid/ready pipelined carry-lookahead adder/subtractor, the general-width successor to the fixed 4-bit CLA slice. It splits a WIDTH-bit operation into GROUP-bit lookahead groups and resolves GROUPS_PER_STAGE groups per pipeline stage. Throughput is one operation per cycle. It feeds the multiplier's partial-product accumulation and any EX-unit path that needs full-width add/sub with backpressure.

## Interface
- WIDTH, 32: operand/sum width; must be a multiple of GROUP*GROUPS_PER_STAGE.
- GROUP, 4: bits per lookahead group.
- GROUPS_PER_STAGE, 2: groups resolved per pipeline stage; NUM_STAGES = WIDTH/(GROUP*GROUPS_PER_STAGE).
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  operation offered
- in_ready  out  1  block accepts this cycle
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B
- in_op  in  1  0 = ADD, 1 = SUB (A − B)
- in_carry  in  1  carry-in for ADD; ignored for SUB
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts
- out_sum  out  WIDTH  result
- out_carry  out  1  carry out of MSB (SUB: 1 = no borrow)
- out_overflow  out  1  signed overflow (flags build only)
- out_zero  out  1  out_sum == 0 (flags build only)

## Operation
- Pre-processing at accept: b_eff = in_op ? ~in_b : in_b; cin = in_op ? 1 : in_carry.
- Stage k (0..NUM_STAGES−1) computes sum bits of slice k from registered carry of stage k−1, using g = a&b, p = a^b, in-group lookahead carries, and group-level generate/propagate chained across its GROUPS_PER_STAGE groups.
- Operand slices for later stages travel in skew registers; completed sum slices travel in de-skew registers, so all WIDTH bits emerge together.
- Each stage holds a valid bit; the last stage's valid bit is out_valid.
- Global advance = !out_valid | out_ready. When advance is 1, every stage loads from its predecessor and stage 0 loads {in_valid, operands}. When advance is 0, all stages hold.
- in_ready = reset & advance. A transfer occurs when in_valid & in_ready. Bubbles are not compressed during a stall.
- out_carry = carry out of bit WIDTH−1. out_overflow = carry into MSB XOR carry out of MSB.
- Output fields are registered and hold stable while out_valid & !out_ready.

## Timing
- Reset asserted: all valid bits = 0 and data registers = 0. out_valid, out_sum, out_carry, out_overflow and out_zero are all 0. in_ready = 0.
- Reset mid-operation: all in-flight operations are discarded. No output is produced for them after release.
- Latency: an op accepted at edge N appears with out_valid = 1 after edge N+NUM_STAGES−1, i.e. NUM_STAGES cycles. Defaults give 4 cycles.
- Stall: each cycle with out_valid & !out_ready adds one cycle of latency to every in-flight op. No op is lost or duplicated.
- Accepting on the same cycle an output is consumed is legal; full throughput is sustained.
- The in_valid=0 cycles propagate as bubbles; out_valid stays 0 for the matching cycle.
- Wrap-around: ADD 0xFFFFFFFF+1 gives sum 0 with carry 1. No saturation.

## Configuration
- CLA_FLAGS_EN defined: out_overflow and out_zero are computed in the final stage and registered alongside out_sum.
- CLA_FLAGS_EN undefined: the flag logic is not built. out_overflow and out_zero are tied to 0. Ports remain, so the interface is unchanged.

## Structure
- cla_pkg: typedef enum logic {CLA_ADD = 1'b0, CLA_SUB = 1'b1} cla_op_e.
- cla_pkg: function or localparam for NUM_STAGES, and default-width constants.
- Sub-module cla_group: combinational GROUP-bit lookahead. Inputs a, b, cin. Outputs sum, group generate, group propagate, cout, and carry into MSB.
- Top: instantiates WIDTH/GROUP cla_group instances, plus the stage, skew and valid registers and the handshake.

## Test plan
- Defaults, out_ready=1: ADD 0x0000_0005 + 0x0000_0003, cin=0 → 4 cycles later out_sum=0x0000_0008, carry=0, zero=0.
- Carry across all stages: ADD 0xFFFF_FFFF + 0x0000_0001 → sum 0x0000_0000, carry=1, zero=1, overflow=0.
- SUB with flags: SUB 0x8000_0000 − 0x0000_0001 → sum 0x7FFF_FFFF, carry=1, overflow=1. SUB 3 − 5 → 0xFFFF_FFFE, carry=0.
- Backpressure: 8 back-to-back random ops, out_ready low for cycles 5–7 → out_valid/data held stable, in_ready=0 during the stall. All 8 results arrive in order and match the model.
- Reset mid-flight: 3 ops accepted, reset pulsed low 1 cycle → all outputs 0 during reset. No stale result afterwards; the next op has 4-cycle latency.
- Parameter sweep WIDTH=16, GROUP=4, GROUPS_PER_STAGE=1, with and without CLA_FLAGS_EN → latency 4, random ADD/SUB results match the model. Flags are 0 when the macro is undefined.
